game_timer: RTL and testbench

//  Countdown game timer for the whack-a-mole round. Consumes the slow 1 Hz square

---
 rtl/game_timer_pkg.sv | 22 ++
 rtl/game_timer_tick_sync.sv | 36 +++
 rtl/game_timer.sv | 140 ++++++++++++++
 tb/tb_game_timer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer: FSM state encodings, BCD digit width
// and the seconds-to-BCD conversion used for the reload value.
package game_timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2*BCD_W-1:0] to_bcd(input int unsigned sec);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(sec / 32'd10);
    ones = BCD_W'(sec % 32'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_timer_tick_sync.sv
// Synchronizes an asynchronous slow square wave into the clk domain and emits a
// registered one-cycle pulse per rising edge, SYNC_STAGES+1 cycles after the edge.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   tick_q, tick_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_timer.sv
// Whack-a-mole round timer: counts BCD seconds down from INIT_SEC on 1 Hz ticks.
// Optional warn output is built only when GAME_TIMER_WARN_EN is defined.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int INIT_SEC    = 60,
  parameter int WARN_SEC    = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_1,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic             timeout,
  output logic             warn
);

  localparam logic [2*BCD_W-1:0] INIT_BCD = to_bcd(INIT_SEC);

  logic             sec_tick;
  logic             start_rise, pause_rise;
  state_e           state_q, state_d;
  logic [BCD_W-1:0] tens_q, tens_d, ones_q, ones_d;
  logic             start_q, pause_q;
  logic             running_q, running_d;
  logic             timeout_q, timeout_d;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (clk_1),
    .tick     (sec_tick)
  );

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start edge reloads; any tick landing in the same cycle is discarded.
        if (start_rise) begin
          state_d          = ST_RUN;
          {tens_d, ones_d} = INIT_BCD;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (sec_tick) begin
          if ({tens_q, ones_q} == 8'h01) begin
            {tens_d, ones_d} = 8'h00;
            timeout_d        = 1'b1;
            state_d          = ST_DONE;
          end else if (ones_q != 4'd0) begin
            ones_d = ones_q - 4'd1;
          end else if (tens_q != 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q;
          end
        end else begin
          ones_d = ones_q;
        end
        if (pause_rise && (state_d == ST_RUN)) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = state_d;
        end
      end
      ST_PAUSE: begin
        if (start_rise) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tens_q    <= INIT_BCD[2*BCD_W-1:BCD_W];
      ones_q    <= INIT_BCD[BCD_W-1:0];
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      running_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      start_q   <= start;
      pause_q   <= pause;
      running_q <= running_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef GAME_TIMER_WARN_EN
  localparam logic [2*BCD_W-1:0] WARN_BCD = to_bcd(WARN_SEC);

  logic warn_q, warn_d;

  // BCD ordering matches numeric ordering, so a plain byte compare suffices.
  always_comb begin
    warn_d = running_d && ({tens_d, ones_d} <= WARN_BCD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= warn_d;
    end
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign running  = running_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer (INIT_SEC=60, WARN_SEC=10,
// SYNC_STAGES=2); warn expectations follow GAME_TIMER_WARN_EN.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       rst_n, clk_1, start, pause;
  logic [3:0] sec_tens, sec_ones;
  logic       running, timeout, warn;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int timeout_cnt = 0;

  game_timer #(.INIT_SEC(60), .WARN_SEC(10), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_1    (clk_1),
    .start    (start),
    .pause    (pause),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .timeout  (timeout),
    .warn     (warn)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (timeout === 1'b1) timeout_cnt <= timeout_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Digits, running flag and the warn level implied by them.
  task automatic chk_st(input string tag, input logic [3:0] t, input logic [3:0] o,
                        input logic run);
    logic w;
`ifdef GAME_TIMER_WARN_EN
    w = run && ({t, o} <= 8'h10);
`else
    w = 1'b0;
`endif
    chk({tag, ".tens"}, {28'd0, sec_tens}, {28'd0, t});
    chk({tag, ".ones"}, {28'd0, sec_ones}, {28'd0, o});
    chk({tag, ".running"}, {31'd0, running}, {31'd0, run});
    chk({tag, ".warn"}, {31'd0, warn}, {31'd0, w});
  endtask

  task automatic tick_once();
    clk_1 = 1'b1;
    step(4);
    clk_1 = 1'b0;
    step(4);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic press_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_1 = 1'b0; start = 1'b0; pause = 1'b0;
    step(2);
    chk_st("reset", 4'd6, 4'd0, 1'b0);
    chk("reset.timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    step(1);
    start = 1'b1;
    step(1);
    chk_st("start", 4'd6, 4'd0, 1'b1);
    start = 1'b0;
    step(1);

    // Tick latency: pulse after 3 edges, digits move on the 4th.
    clk_1 = 1'b1;
    step(2);
    chk("tick_early", {31'd0, dut.sec_tick}, 32'd0);
    step(1);
    chk("tick_on", {31'd0, dut.sec_tick}, 32'd1);
    chk_st("pre_dec", 4'd6, 4'd0, 1'b1);
    step(1);
    chk("tick_off", {31'd0, dut.sec_tick}, 32'd0);
    chk_st("dec59", 4'd5, 4'd9, 1'b1);
    clk_1 = 1'b0;
    step(4);
    ticks(2);
    chk_st("three_ticks", 4'd5, 4'd7, 1'b1);

    ticks(47);
    chk_st("at10", 4'd1, 4'd0, 1'b1);
    tick_once();
    chk_st("borrow09", 4'd0, 4'd9, 1'b1);
    ticks(8);
    chk_st("at01", 4'd0, 4'd1, 1'b1);
    chk("no_early_timeout", timeout_cnt, 32'd0);
    clk_1 = 1'b1;
    step(4);
    chk_st("done00", 4'd0, 4'd0, 1'b0);
    chk("timeout_hi", {31'd0, timeout}, 32'd1);
    step(1);
    chk("timeout_lo", {31'd0, timeout}, 32'd0);
    clk_1 = 1'b0;
    step(4);
    ticks(2);
    chk_st("done_hold", 4'd0, 4'd0, 1'b0);
    chk("one_timeout", timeout_cnt, 32'd1);

    // Start edge lands on the same cycle the DONE-state tick is consumed.
    clk_1 = 1'b1;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk_st("reload_wins", 4'd6, 4'd0, 1'b1);
    clk_1 = 1'b0;
    step(4);
    chk_st("reload_hold", 4'd6, 4'd0, 1'b1);

    ticks(15);
    chk_st("at45", 4'd4, 4'd5, 1'b1);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk_st("paused", 4'd4, 4'd5, 1'b0);
    ticks(2);
    chk_st("pause_drop", 4'd4, 4'd5, 1'b0);
    press_start();
    chk_st("resume", 4'd4, 4'd5, 1'b1);
    step(1);
    tick_once();
    chk_st("after_resume", 4'd4, 4'd4, 1'b1);

    ticks(14);
    chk_st("at30", 4'd3, 4'd0, 1'b1);
    clk_1 = 1'b1;
    step(3);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    chk_st("pause_tick", 4'd2, 4'd9, 1'b0);
    clk_1 = 1'b0;
    step(4);
    tick_once();
    chk_st("pause_tick_hold", 4'd2, 4'd9, 1'b0);

    start = 1'b1; pause = 1'b1;
    step(1);
    start = 1'b0; pause = 1'b0;
    chk_st("both_in_pause", 4'd2, 4'd9, 1'b1);
    step(1);
    start = 1'b1; pause = 1'b1;
    step(1);
    start = 1'b0; pause = 1'b0;
    chk_st("both_in_run", 4'd2, 4'd9, 1'b0);
    step(1);
    press_start();
    step(1);
    ticks(6);
    chk_st("at23", 4'd2, 4'd3, 1'b1);

    rst_n = 1'b0;
    #1;
    chk_st("async_rst", 4'd6, 4'd0, 1'b0);
    chk("async_rst.timeout", {31'd0, timeout}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    tick_once();
    chk_st("idle_ignores_tick", 4'd6, 4'd0, 1'b0);
    chk("no_rst_timeout", timeout_cnt, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
